quad_step_decoder: RTL and testbench

Quadrature encoder front end that directly feeds the 4-bit up/down `counter`. Synchronises the asynchronous A/B/index encoder lines, optionally glitch-filters them, decodes x4 quadrature steps into one-cycle `en` pulses with a `dir` qualifier, and converts an index edge into a `ld`/`ld_val` home-load. All outputs are registered and wire straight onto the counter's `en`, `dir`, `ld` and `ld_val` inputs; the counter's `rst` is shared.

---
 rtl/quad_step_decoder.sv | 158 +++++++++++++++
 tb/tb_quad_step_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises A/B/index, decodes x4 steps into en/dir pulses
// and index rises into ld pulses. Define QUAD_FILTER_EN to compile in per-input glitch filters.
module quad_step_decoder #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 4,
  parameter logic [3:0] HOME_VAL    = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       idx_in,
  input  logic       err_clr,
  output logic       en,
  output logic       dir,
  output logic       ld,
  output logic [3:0] ld_val,
  output logic       err
);

  // state  | meaning
  // ARM    | settling after reset; prev_ab/prev_i track inputs, no outputs
  // RUN    | decode steps and index rises
  // RESYNC | one cycle with en suppressed while prev_ab reloads after an illegal jump

  typedef enum logic [1:0] {ARM, RUN, RESYNC} state_t;

`ifdef QUAD_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int ARM_LEN = SYNC_STAGES + (FILT_EN ? FILT_CYCLES : 0);
  localparam int ARM_W   = (ARM_LEN > 15) ? 5 : 4;
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(ARM_LEN);

  logic [SYNC_STAGES-1:0] a_sync, b_sync, i_sync;
  logic [2:0]             raw;
  logic                   sa, sb, si;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
      i_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
      i_sync <= {i_sync[SYNC_STAGES-2:0], idx_in};
    end
  end

  assign raw = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1], i_sync[SYNC_STAGES-1]};

`ifdef QUAD_FILTER_EN
  localparam logic [3:0] FC_LAST = 4'(FILT_CYCLES - 1);
  logic [2:0]      filt;
  logic [2:0][3:0] fcnt;

  // Output follows the input only after FILT_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      fcnt <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (raw[j] == filt[j]) begin
          fcnt[j] <= 4'd0;
        end else if (fcnt[j] == FC_LAST) begin
          filt[j] <= raw[j];
          fcnt[j] <= 4'd0;
        end else begin
          fcnt[j] <= fcnt[j] + 4'd1;
        end
      end
    end
  end

  assign {sa, sb, si} = filt;
`else
  assign {sa, sb, si} = raw;
`endif

  state_t           state, state_n;
  logic [ARM_W-1:0] arm_cnt, arm_cnt_n;
  logic [1:0]       prev_ab, prev_ab_n, cur_ab;
  logic             prev_i, prev_i_n;
  logic             en_n, dir_n, ld_n, err_n;
  logic             fwd, rev, illegal, idx_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARM;
      arm_cnt <= ARM_INIT;
      prev_ab <= 2'b00;
      prev_i  <= 1'b0;
      en      <= 1'b0;
      dir     <= 1'b1;
      ld      <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      arm_cnt <= arm_cnt_n;
      prev_ab <= prev_ab_n;
      prev_i  <= prev_i_n;
      en      <= en_n;
      dir     <= dir_n;
      ld      <= ld_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    arm_cnt_n = arm_cnt;
    cur_ab    = {sa, sb};
    prev_ab_n = cur_ab;
    prev_i_n  = si;
    en_n      = 1'b0;
    dir_n     = dir;
    ld_n      = 1'b0;
    err_n     = err_clr ? 1'b0 : err;

    fwd = (prev_ab == 2'b00 && cur_ab == 2'b10) || (prev_ab == 2'b10 && cur_ab == 2'b11) ||
          (prev_ab == 2'b11 && cur_ab == 2'b01) || (prev_ab == 2'b01 && cur_ab == 2'b00);
    rev = (prev_ab == 2'b00 && cur_ab == 2'b01) || (prev_ab == 2'b01 && cur_ab == 2'b11) ||
          (prev_ab == 2'b11 && cur_ab == 2'b10) || (prev_ab == 2'b10 && cur_ab == 2'b00);
    illegal  = (cur_ab == ~prev_ab);
    idx_rise = si & ~prev_i;

    case (state)
      ARM: begin
        if (arm_cnt == '0) state_n = RUN;
        else               arm_cnt_n = arm_cnt - 1'b1;
      end
      RUN: begin
        ld_n = idx_rise;
        // A home load overrides a step decoded in the same cycle.
        if ((fwd || rev) && !idx_rise) begin
          en_n  = 1'b1;
          dir_n = fwd;
        end
        if (illegal) begin
          err_n   = 1'b1;
          state_n = RESYNC;
        end
      end
      RESYNC: begin
        ld_n    = idx_rise;
        state_n = RUN;
      end
      default: state_n = ARM;
    endcase
  end

  assign ld_val = HOME_VAL;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: table of held input segments with expected pulse
// counts, plus hand sequences for latency, err set/clear races, back-to-back steps and reset.
module tb_quad_step_decoder;
  localparam int         S  = 2;
  localparam int         F  = 4;
  localparam logic [3:0] HV = 4'b1010;
`ifdef QUAD_FILTER_EN
  localparam int LAT = S + F + 1;
`else
  localparam int LAT = S + 1;
`endif

  logic       clk = 1'b0;
  logic       rst, a_in, b_in, idx_in, err_clr;
  logic       en, dir, ld, err;
  logic [3:0] ld_val;

  int checks = 0;
  int fails  = 0;

  quad_step_decoder #(.SYNC_STAGES(S), .FILT_CYCLES(F), .HOME_VAL(HV)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in), .err_clr(err_clr),
    .en(en), .dir(dir), .ld(ld), .ld_val(ld_val), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a, b, idx;
    int   hold;
    int   n_en, n_ld;
    logic dir, err;
  } vec_t;

  vec_t tbl[17];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_row(input int r);
    int ne, nl;
    ne = 0;
    nl = 0;
    a_in   = tbl[r].a;
    b_in   = tbl[r].b;
    idx_in = tbl[r].idx;
    repeat (tbl[r].hold) begin
      cyc();
      ne += int'(en);
      nl += int'(ld);
      if (ld) chk($sformatf("row%0d ld_val", r), {4'd0, ld_val}, {4'd0, HV});
    end
    chk($sformatf("row%0d en count", r), 8'(ne), 8'(tbl[r].n_en));
    chk($sformatf("row%0d ld count", r), 8'(nl), 8'(tbl[r].n_ld));
    chk($sformatf("row%0d dir", r), {7'd0, dir}, {7'd0, tbl[r].dir});
    chk($sformatf("row%0d err", r), {7'd0, err}, {7'd0, tbl[r].err});
  endtask

  // Drive a new A/B pair and require en exactly LAT edges later, with the given dir.
  task automatic lat_check(input logic a, input logic b, input logic exp_dir, input string nm);
    a_in = a;
    b_in = b;
    for (int i = 1; i <= LAT + 1; i++) begin
      cyc();
      chk($sformatf("%s en@%0d", nm, i), {7'd0, en}, {7'd0, (i == LAT)});
      if (i == LAT) chk($sformatf("%s dir", nm), {7'd0, dir}, {7'd0, exp_dir});
    end
  endtask

  initial begin
    //            a     b     idx   hold en ld dir   err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 10, 1, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 20, 0, 0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 10, 0, 1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 10, 0, 1, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 1'b0, 1'b0};

    rst = 1'b1; a_in = 1'b0; b_in = 1'b0; idx_in = 1'b0; err_clr = 1'b0;
    repeat (3) cyc();
    chk("reset en", {7'd0, en}, 8'd0);
    chk("reset dir", {7'd0, dir}, 8'd1);
    chk("reset ld", {7'd0, ld}, 8'd0);
    chk("reset err", {7'd0, err}, 8'd0);
    chk("reset ld_val", {4'd0, ld_val}, {4'd0, HV});
    rst = 1'b0;
    repeat (12) cyc();

    for (int r = 0; r < 12; r++) run_row(r);

    err_clr = 1'b1;
    cyc();
    chk("err cleared", {7'd0, err}, 8'd0);
    err_clr = 1'b0;
    cyc();
    chk("err stays clear", {7'd0, err}, 8'd0);

    for (int r = 12; r < 17; r++) run_row(r);

    // Illegal 10->01 with err_clr sampled on the same edge: set wins.
    a_in = 1'b0;
    b_in = 1'b1;
    repeat (LAT - 1) cyc();
    err_clr = 1'b1;
    cyc();
    chk("set-vs-clr err", {7'd0, err}, 8'd1);
    chk("set-vs-clr en", {7'd0, en}, 8'd0);
    err_clr = 1'b0;
    repeat (5) cyc();
    chk("err sticky", {7'd0, err}, 8'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err clear 2", {7'd0, err}, 8'd0);
    repeat (5) cyc();

    lat_check(1'b0, 1'b0, 1'b1, "latency fwd");
    repeat (5) cyc();

`ifndef QUAD_FILTER_EN
    begin
      logic [1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
      for (int t = 0; t < 9; t++) begin
        if (t < 4) {a_in, b_in} = seq[t];
        cyc();
        chk($sformatf("b2b en t%0d", t + 1), {7'd0, en},
            {7'd0, (t + 1 >= LAT && t + 1 <= LAT + 3)});
        if (t + 1 >= LAT && t + 1 <= LAT + 3) chk($sformatf("b2b dir t%0d", t + 1), {7'd0, dir}, 8'd0);
      end
    end
    repeat (3) cyc();
`endif

    // Asynchronous reset while en is high.
    a_in = 1'b0;
    b_in = 1'b1;
    repeat (LAT) cyc();
    chk("pre-reset en", {7'd0, en}, 8'd1);
    chk("pre-reset dir", {7'd0, dir}, 8'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset en", {7'd0, en}, 8'd0);
    chk("async reset dir", {7'd0, dir}, 8'd1);
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    begin
      int ne, nl;
      ne = 0;
      nl = 0;
      repeat (LAT + 12) begin
        cyc();
        ne += int'(en);
        nl += int'(ld);
      end
      chk("arm hold11 en", 8'(ne), 8'd0);
      chk("arm hold11 ld", 8'(nl), 8'd0);
      chk("arm hold11 err", {7'd0, err}, 8'd0);
    end
    lat_check(1'b0, 1'b1, 1'b1, "post-reset fwd");
    repeat (5) cyc();

`ifdef QUAD_FILTER_EN
    begin
      int ne;
      ne = 0;
      a_in = 1'b1;
      repeat (2) begin
        cyc();
        ne += int'(en);
      end
      a_in = 1'b0;
      repeat (20) begin
        cyc();
        ne += int'(en);
      end
      chk("glitch en count", 8'(ne), 8'd0);
    end
    lat_check(1'b1, 1'b1, 1'b0, "filtered rev");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
